// File: rtl/tester_pkg.sv
// Shared definitions for the tester pipeline: stimulus/response word layout,
// op codes and the dut_driver state encoding.
package tester_pkg;

   typedef enum logic [1:0] {
      OP_APPLY        = 2'b00,
      OP_APPLY_SAMPLE = 2'b01,
      OP_HOLD_SAMPLE  = 2'b10,
      OP_RESERVED     = 2'b11
   } op_e;

   localparam int OP_HI     = 23;
   localparam int OP_LO     = 22;
   localparam int SETTLE_HI = 21;
   localparam int SETTLE_LO = 16;
   localparam int VEC_HI    = 15;
   localparam int VEC_LO    = 0;
   localparam int SEQ_HI    = 23;
   localparam int SEQ_LO    = 16;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_FETCH  = 3'd1;
   localparam state_t ST_DRIVE  = 3'd2;
   localparam state_t ST_SETTLE = 3'd3;
   localparam state_t ST_SAMPLE = 3'd4;
   localparam state_t ST_PUSH   = 3'd5;

   function automatic logic [23:0] encode_word(op_e op, logic [5:0] settle, logic [15:0] vec);
      return {op, settle, vec};
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Parameterised-width flop chain for bringing asynchronous DUT outputs into
// the test clock domain; STAGES=0 passes the input straight through.
module sync_ff #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (STAGES == 0) begin : g_direct
         assign q_o = d_i;
      end else begin : g_chain
         logic [WIDTH-1:0] chain_q [STAGES];

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
            end else begin
               chain_q[0] <= d_i;
               for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
            end
         end

         assign q_o = chain_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/dut_driver.sv
// Test-clock stage: pops stimulus words, drives DUT input pins, waits the
// per-word settle time, samples DUT outputs and pushes tagged responses.
module dut_driver
   import tester_pkg::*;
#(
   parameter int DUT_IN_WIDTH  = 16,
   parameter int DUT_OUT_WIDTH = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [23:0]              sfifo_data,
   output logic                     sfifo_rdreq,
   input  logic                     sfifo_rdempty,
   output logic [23:0]              rfifo_data,
   output logic                     rfifo_wrreq,
   input  logic                     rfifo_wrfull,
   output logic [DUT_IN_WIDTH-1:0]  dut_in,
   input  logic [DUT_OUT_WIDTH-1:0] dut_out,
   output logic                     busy,
   output logic [15:0]              vec_count,
   output logic                     bad_op
);

   state_t                   state_q, state_d;
   op_e                      op_q;
   logic [5:0]               settle_q;
   logic [5:0]               cnt_q;
   logic [DUT_IN_WIDTH-1:0]  vec_q;
   logic [DUT_IN_WIDTH-1:0]  dut_in_q;
   logic [7:0]               seq_q;
   logic [15:0]              vec_count_q;
   logic                     bad_op_q;
   logic [23:0]              rfifo_data_q;
   logic [DUT_OUT_WIDTH-1:0] dut_out_s;
   op_e                      fetch_op;

   sync_ff #(
      .WIDTH  (DUT_OUT_WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     (dut_out),
      .q_o     (dut_out_s)
   );

   assign fetch_op = op_e'(sfifo_data[OP_HI:OP_LO]);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (!sfifo_rdempty) state_d = ST_FETCH;
         ST_FETCH:  state_d = (fetch_op == OP_RESERVED) ? ST_IDLE : ST_DRIVE;
         ST_DRIVE:  state_d = (settle_q == 6'd0) ? ST_SAMPLE : ST_SETTLE;
         ST_SETTLE: if (cnt_q == 6'd1) state_d = ST_SAMPLE;
         ST_SAMPLE: state_d = (op_q == OP_APPLY) ? ST_IDLE : ST_PUSH;
         ST_PUSH:   if (!rfifo_wrfull) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_APPLY;
         settle_q     <= '0;
         cnt_q        <= '0;
         vec_q        <= '0;
         dut_in_q     <= '0;
         seq_q        <= '0;
         vec_count_q  <= '0;
         bad_op_q     <= 1'b0;
         rfifo_data_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_FETCH: begin
               op_q     <= fetch_op;
               settle_q <= sfifo_data[SETTLE_HI:SETTLE_LO];
               vec_q    <= sfifo_data[VEC_LO +: DUT_IN_WIDTH];
               if (fetch_op == OP_RESERVED) bad_op_q <= 1'b1;
            end
            ST_DRIVE: begin
               if (op_q != OP_HOLD_SAMPLE) dut_in_q <= vec_q;
               cnt_q <= settle_q;
            end
            ST_SETTLE: cnt_q <= cnt_q - 6'd1;
            // Response word is frozen here so it stays stable through any backpressure
            ST_SAMPLE: if (op_q != OP_APPLY) rfifo_data_q <= {seq_q, 16'(dut_out_s)};
            ST_PUSH: begin
               if (!rfifo_wrfull) begin
                  seq_q       <= seq_q + 8'd1;
                  vec_count_q <= vec_count_q + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // FIFO strobes gate on the live flags so a flag change is honoured the same cycle
   assign sfifo_rdreq = (state_q == ST_IDLE) && !sfifo_rdempty;
   assign rfifo_wrreq = (state_q == ST_PUSH) && !rfifo_wrfull;
   assign rfifo_data  = rfifo_data_q;
   assign dut_in      = dut_in_q;
   assign busy        = (state_q != ST_IDLE);
   assign vec_count   = vec_count_q;
   assign bad_op      = bad_op_q;

endmodule

// File: tb/tb_dut_driver.sv
// Scoreboard bench for dut_driver with a loopback DUT model and FIFO models.
module tb_dut_driver;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [23:0] sfifo_data = '0;
   logic        sfifo_rdreq;
   logic        sfifo_rdempty = 1'b1;
   logic [23:0] rfifo_data;
   logic        rfifo_wrreq;
   logic        rfifo_wrfull = 1'b0;
   logic [15:0] dut_in;
   logic [15:0] dut_out;
   logic        busy;
   logic [15:0] vec_count;
   logic        bad_op;

   int          errors = 0;
   int          checks = 0;
   int          push_cnt = 0;
   logic [23:0] last_rsp = '0;
   logic [7:0]  seq_m = '0;
   logic        prev_rdreq = 1'b0;

   logic [23:0] stim_q[$];
   logic [23:0] exp_q[$];

   dut_driver #(
      .DUT_IN_WIDTH  (16),
      .DUT_OUT_WIDTH (16),
      .SYNC_STAGES   (2)
   ) u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .sfifo_data    (sfifo_data),
      .sfifo_rdreq   (sfifo_rdreq),
      .sfifo_rdempty (sfifo_rdempty),
      .rfifo_data    (rfifo_data),
      .rfifo_wrreq   (rfifo_wrreq),
      .rfifo_wrfull  (rfifo_wrfull),
      .dut_in        (dut_in),
      .dut_out       (dut_out),
      .busy          (busy),
      .vec_count     (vec_count),
      .bad_op        (bad_op)
   );

   assign dut_out = dut_in;

   always #50 clock = ~clock;

   // Stimulus FIFO model: normal mode, data valid the cycle after rdreq
   always @(posedge clock) begin
      if (sfifo_rdreq && stim_q.size() > 0) sfifo_data <= stim_q.pop_front();
      sfifo_rdempty <= (stim_q.size() == 0);
   end

   // Response monitor and protocol watch
   always @(negedge clock) begin
      if (reset_n) begin
         checks++;
         if (sfifo_rdreq && sfifo_rdempty) begin
            errors++;
            $display("FAIL rdreq_when_empty: got rdreq=1 with rdempty=1, required rdreq=0");
         end
         checks++;
         if (sfifo_rdreq && prev_rdreq) begin
            errors++;
            $display("FAIL rdreq_back_to_back: got rdreq=1 two cycles running, required single pulse");
         end
         checks++;
         if (rfifo_wrreq && rfifo_wrfull) begin
            errors++;
            $display("FAIL wrreq_when_full: got wrreq=1 with wrfull=1, required wrreq=0");
         end
         if (rfifo_wrreq) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL push_unexpected: got push %h, required no push", rfifo_data);
            end else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               if (rfifo_data !== e) begin
                  errors++;
                  $display("FAIL push_data: got %h required %h", rfifo_data, e);
               end
            end
            push_cnt++;
            last_rsp = rfifo_data;
         end
         prev_rdreq = sfifo_rdreq;
      end else begin
         prev_rdreq = 1'b0;
      end
   end

   task automatic wait_rdreq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (sfifo_rdreq) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_drain(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && stim_q.size() == 0 && sfifo_rdempty && !busy) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [5:0] settle, input logic [15:0] vec,
                       input logic [15:0] expect_vec);
      stim_q.push_back({op, settle, vec});
      if (op == 2'b01 || op == 2'b10) begin
         exp_q.push_back({seq_m, expect_vec});
         seq_m = seq_m + 8'd1;
      end
   endtask

   task automatic test_reset;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || dut_in !== 16'h0 || sfifo_rdreq !== 1'b0 || rfifo_wrreq !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy=%b dut_in=%h rdreq=%b wrreq=%b, required 0", busy, dut_in, sfifo_rdreq, rfifo_wrreq);
      end
      checks++;
      if (vec_count !== 16'h0 || bad_op !== 1'b0 || rfifo_data !== 24'h0) begin
         errors++;
         $display("FAIL reset_data: got vec_count=%h bad_op=%b rfifo_data=%h, required 0", vec_count, bad_op, rfifo_data);
      end
      @(posedge clock); #1 reset_n = 1'b1;
   endtask

   task automatic test_apply_sample;
      bit ok;
      @(posedge clock); #1;
      send(2'b01, 6'd3, 16'h00A5, 16'h00A5);
      wait_rdreq(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL as_rdreq: got no rdreq, required rdreq"); end
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (dut_in !== 16'h0000) begin errors++; $display("FAIL as_dut_in_early: got %h required 0000", dut_in); end
      @(negedge clock);
      checks++;
      if (dut_in !== 16'h00A5) begin errors++; $display("FAIL as_dut_in: got %h required 00a5", dut_in); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if (rfifo_wrreq !== 1'b0) begin errors++; $display("FAIL as_wrreq_early: got 1 required 0 at %0d", i); end
      end
      @(negedge clock);
      checks++;
      if (rfifo_wrreq !== 1'b1 || rfifo_data !== 24'h0000A5) begin
         errors++;
         $display("FAIL as_push: got wrreq=%b data=%h required 1 0000a5", rfifo_wrreq, rfifo_data);
      end
      @(negedge clock);
      checks++;
      if (vec_count !== 16'd1) begin errors++; $display("FAIL as_vec_count: got %0d required 1", vec_count); end
   endtask

   task automatic test_apply_hold;
      bit ok;
      int p0;
      bit seen;
      p0 = push_cnt;
      seen = 1'b0;
      @(posedge clock); #1;
      send(2'b00, 6'd1, 16'h1234, 16'h0);
      send(2'b10, 6'd0, 16'hFFFF, 16'h1234);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (dut_in === 16'h1234) seen = 1'b1;
         if (seen) begin
            checks++;
            if (dut_in !== 16'h1234) begin errors++; $display("FAIL ah_dut_in_hold: got %h required 1234", dut_in); end
         end
         if (exp_q.size() == 0 && stim_q.size() == 0 && sfifo_rdempty && !busy) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok || !seen) begin errors++; $display("FAIL ah_drain: got ok=%b seen=%b required 1 1", ok, seen); end
      checks++;
      if (push_cnt - p0 != 1) begin errors++; $display("FAIL ah_push_count: got %0d required 1", push_cnt - p0); end
   endtask

   task automatic test_backpressure;
      bit ok;
      logic [23:0] e;
      e = {seq_m, 16'h5A5A};
      @(posedge clock); #1;
      rfifo_wrfull = 1'b1;
      send(2'b01, 6'd2, 16'h5A5A, 16'h5A5A);
      wait_rdreq(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_rdreq: got no rdreq, required rdreq"); end
      stim_q.push_back({2'b00, 6'd0, 16'h7777});
      for (int i = 0; i < 5; i++) @(negedge clock);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checks++;
         if (rfifo_wrreq !== 1'b0 || sfifo_rdreq !== 1'b0 || rfifo_data !== e || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got wrreq=%b rdreq=%b data=%h busy=%b required 0 0 %h 1", rfifo_wrreq, sfifo_rdreq, rfifo_data, busy, e);
         end
      end
      @(posedge clock); #1 rfifo_wrfull = 1'b0;
      @(negedge clock);
      checks++;
      if (rfifo_wrreq !== 1'b1) begin errors++; $display("FAIL bp_release: got wrreq=%b required 1", rfifo_wrreq); end
      @(negedge clock);
      checks++;
      if (rfifo_wrreq !== 1'b0) begin errors++; $display("FAIL bp_single: got wrreq=%b required 0", rfifo_wrreq); end
      wait_drain(50, ok);
      checks++;
      if (!ok || dut_in !== 16'h7777) begin errors++; $display("FAIL bp_next_word: got ok=%b dut_in=%h required 1 7777", ok, dut_in); end
   endtask

   task automatic test_reserved;
      bit ok;
      int p0;
      p0 = push_cnt;
      @(posedge clock); #1;
      stim_q.push_back(24'hC0FFFF);
      wait_rdreq(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rsv_rdreq: got no rdreq, required rdreq"); end
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || bad_op !== 1'b1 || dut_in !== 16'h7777 || push_cnt != p0) begin
         errors++;
         $display("FAIL rsv_discard: got busy=%b bad_op=%b dut_in=%h pushes=%0d required 0 1 7777 0", busy, bad_op, dut_in, push_cnt - p0);
      end
      @(posedge clock); #1;
      send(2'b01, 6'd2, 16'h0F0F, 16'h0F0F);
      wait_drain(50, ok);
      checks++;
      if (!ok || bad_op !== 1'b1 || dut_in !== 16'h0F0F || push_cnt - p0 != 1) begin
         errors++;
         $display("FAIL rsv_follow: got ok=%b bad_op=%b dut_in=%h pushes=%0d required 1 1 0f0f 1", ok, bad_op, dut_in, push_cnt - p0);
      end
   endtask

   task automatic test_reset_mid_settle;
      bit ok;
      @(posedge clock); #1;
      send(2'b00, 6'd40, 16'hBEEF, 16'h0);
      wait_rdreq(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rm_rdreq: got no rdreq, required rdreq"); end
      for (int i = 0; i < 6; i++) @(negedge clock);
      checks++;
      if (dut_in !== 16'hBEEF || busy !== 1'b1) begin errors++; $display("FAIL rm_settle: got dut_in=%h busy=%b required beef 1", dut_in, busy); end
      @(posedge clock); #1 reset_n = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || dut_in !== 16'h0 || rfifo_wrreq !== 1'b0 || bad_op !== 1'b0 || vec_count !== 16'h0) begin
         errors++;
         $display("FAIL rm_reset: got busy=%b dut_in=%h wrreq=%b bad_op=%b vec_count=%h required all 0", busy, dut_in, rfifo_wrreq, bad_op, vec_count);
      end
      seq_m = '0;
      @(posedge clock); #1 reset_n = 1'b1;
   endtask

   task automatic test_seq_wrap;
      bit ok;
      int p0;
      logic [15:0] v;
      p0 = push_cnt;
      @(posedge clock); #1;
      for (int i = 0; i < 257; i++) begin
         v = 16'($urandom);
         send(2'b01, 6'd2, v, v);
      end
      wait_drain(257 * 8 + 100, ok);
      checks++;
      if (!ok || push_cnt - p0 != 257) begin errors++; $display("FAIL sw_drain: got ok=%b pushes=%0d required 1 257", ok, push_cnt - p0); end
      checks++;
      if (last_rsp[23:16] !== 8'h00 || last_rsp[15:0] !== v) begin
         errors++;
         $display("FAIL sw_last: got %h required %h", last_rsp, {8'h00, v});
      end
      checks++;
      if (vec_count !== 16'd257) begin errors++; $display("FAIL sw_vec_count: got %0d required 257", vec_count); end
   endtask

   task automatic test_empty;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checks++;
         if (sfifo_rdreq !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_idle: got rdreq=%b busy=%b required 0 0", sfifo_rdreq, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_apply_sample();
      test_apply_hold();
      test_backpressure();
      test_reserved();
      test_reset_mid_settle();
      test_seq_wrap();
      test_empty();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expect: got %0d required 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
